// File: rtl/lmi_dram_route_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lmi_dram_route_pkg
// Description : Shared symbols for the LMI request router: window field
//               positions, config select encodings and the queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package lmi_dram_route_pkg;

    localparam int   C_LM_BASE_LO     = 12;
    localparam int   C_LM_TOP_HI      = 23;
    localparam int   C_LM_TOP_LO      = 4;

    localparam logic C_LMI_CFG_BASE   = 1'b0;
    localparam logic C_LMI_CFG_TOP    = 1'b1;
    localparam int   C_LMI_CFG_EN_BIT = 0;

    localparam int   C_QDEPTH         = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        route;   // 1 = DRAM window, 0 = system bus
    } lmi_req_t;

endpackage
`default_nettype wire

// File: rtl/lmi_dram_cmp.sv
`default_nettype none
// ============================================================================
// Module      : lmi_dram_cmp
// Description : DRAM window hit test of a request address against BASE/TOP.
// Revision    : 1.0 - initial release
// ============================================================================
module lmi_dram_cmp
    import lmi_dram_route_pkg::*;
#(
    parameter int BASE_LO = C_LM_BASE_LO,
    parameter int TOP_HI  = C_LM_TOP_HI,
    parameter int TOP_LO  = C_LM_TOP_LO
) (
    input  logic [31:TOP_LO]      i_addr,
    input  logic                  i_en,
    input  logic [31:BASE_LO]     i_base,
    input  logic [TOP_HI:TOP_LO]  i_top,
    output logic                  o_hit
);

    logic w_hi_eq;
    logic w_ge_base;
    logic w_le_top;

    // Bits above TOP_HI select the region; the two magnitude tests bound it.
    assign w_hi_eq   = (i_addr[31:TOP_HI+1] == i_base[31:TOP_HI+1]);
    assign w_ge_base = (i_addr[TOP_HI:BASE_LO] >= i_base[TOP_HI:BASE_LO]);
    assign w_le_top  = (i_addr[TOP_HI:TOP_LO] <= i_top);

    assign o_hit = i_en & w_hi_eq & w_ge_base & w_le_top;

endmodule
`default_nettype wire

// File: rtl/lmi_dram_route.sv
`default_nettype none
// ============================================================================
// Module      : lmi_dram_route
// Description : 2-entry in-order request queue that tags each request as
//               DRAM-window or system-bus at accept and steers the head.
// Revision    : 1.0 - initial release
// ============================================================================
module lmi_dram_route
    import lmi_dram_route_pkg::*;
#(
    parameter int BASE_LO = C_LM_BASE_LO,
    parameter int TOP_HI  = C_LM_TOP_HI,
    parameter int TOP_LO  = C_LM_TOP_LO
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cfg_we,
    input  logic        i_cfg_sel,
    input  logic [31:0] i_cfg_wdata,
    output logic [31:0] o_cfg_base,
    output logic [31:0] o_cfg_top,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_wr,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_be,
    output logic        o_dram_valid,
    input  logic        i_dram_ready,
    output logic        o_sys_valid,
    input  logic        i_sys_ready,
    output logic [31:0] o_out_addr,
    output logic        o_out_wr,
    output logic [31:0] o_out_wdata,
    output logic [3:0]  o_out_be
);

    lmi_req_t              r_mem [C_QDEPTH];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic [31:BASE_LO]     r_base;
    logic                  r_en;
    logic [TOP_HI:TOP_LO]  r_top;

    logic                  r_req_ready;
    logic                  r_dram_valid;
    logic                  r_sys_valid;
    logic [31:0]           r_out_addr;
    logic                  r_out_wr;
    logic [31:0]           r_out_wdata;
    logic [3:0]            r_out_be;

    logic                  w_hit;
    logic                  w_accept;
    logic                  w_pop;
    logic [1:0]            w_count_next;
    logic                  w_rd_next;
    lmi_req_t              w_in;
    lmi_req_t              w_head_next;
    logic [31:0]           w_cfg_base;
    logic [31:0]           w_cfg_top;
    logic                  w_cfg_unused;

    lmi_dram_cmp #(
        .BASE_LO (BASE_LO),
        .TOP_HI  (TOP_HI),
        .TOP_LO  (TOP_LO)
    ) u_cmp (
        .i_addr  (i_req_addr[31:TOP_LO]),
        .i_en    (r_en),
        .i_base  (r_base),
        .i_top   (r_top),
        .o_hit   (w_hit)
    );

    assign w_accept = i_req_valid & r_req_ready;
    assign w_pop    = (r_dram_valid & i_dram_ready) | (r_sys_valid & i_sys_ready);
    assign w_rd_next = r_rd_ptr ^ w_pop;

    assign w_in = '{addr:  i_req_addr,
                    wr:    i_req_wr,
                    wdata: i_req_wdata,
                    be:    i_req_be,
                    route: w_hit};

    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_accept && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    // The next head is the entry being written this edge when the read pointer
    // lands on the write slot; otherwise it is already in storage.
    always_comb begin
        w_head_next = r_mem[w_rd_next];
        if (w_accept && (r_wr_ptr == w_rd_next)) begin
            w_head_next = w_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_req_ready  <= 1'b1;
            r_dram_valid <= 1'b0;
            r_sys_valid  <= 1'b0;
            r_out_addr   <= 32'd0;
            r_out_wr     <= 1'b0;
            r_out_wdata  <= 32'd0;
            r_out_be     <= 4'd0;
        end else begin
            r_wr_ptr    <= r_wr_ptr ^ w_accept;
            r_rd_ptr    <= w_rd_next;
            r_count     <= w_count_next;
            r_req_ready <= (w_count_next < 2'd2);
            if (w_count_next != 2'd0) begin
                r_dram_valid <= w_head_next.route;
                r_sys_valid  <= ~w_head_next.route;
                r_out_addr   <= w_head_next.addr;
                r_out_wr     <= w_head_next.wr;
                r_out_wdata  <= w_head_next.wdata;
                r_out_be     <= w_head_next.be;
            end else begin
                r_dram_valid <= 1'b0;
                r_sys_valid  <= 1'b0;
            end
        end
    end

    // Route bits are captured at accept, so a write here never alters queued entries.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base <= '0;
            r_en   <= 1'b0;
            r_top  <= '0;
        end else if (i_cfg_we) begin
            if (i_cfg_sel == C_LMI_CFG_BASE) begin
                r_base <= i_cfg_wdata[31:BASE_LO];
                r_en   <= i_cfg_wdata[C_LMI_CFG_EN_BIT];
            end else begin
                r_top  <= i_cfg_wdata[TOP_HI:TOP_LO];
            end
        end
    end

    always_comb begin
        w_cfg_base                   = '0;
        w_cfg_base[31:BASE_LO]       = r_base;
        w_cfg_base[C_LMI_CFG_EN_BIT] = r_en;
        w_cfg_top                    = '0;
        w_cfg_top[TOP_HI:TOP_LO]     = r_top;
    end

    assign w_cfg_unused = ^i_cfg_wdata;

    assign o_cfg_base   = w_cfg_base;
    assign o_cfg_top    = w_cfg_top;
    assign o_req_ready  = r_req_ready;
    assign o_dram_valid = r_dram_valid;
    assign o_sys_valid  = r_sys_valid;
    assign o_out_addr   = r_out_addr;
    assign o_out_wr     = r_out_wr;
    assign o_out_wdata  = r_out_wdata;
    assign o_out_be     = r_out_be;

endmodule
`default_nettype wire

// File: doc/lmi_dram_route.md
Name: lmi_dram_route

Overview:
Request-steering stage placed directly upstream of the LMI DRAM window comparator.
- Accepts CPU-side load/store requests through a valid/ready handshake.
- Buffers them in a 2-entry in-order queue.
- Tags each request at acceptance as DRAM-window or system-bus, using the programmable BASE/TOP window registers it owns.
- Presents the head request on exactly one of two downstream ports: DRAM or SYS.

Parameters:
BASE_LO, `LM_BASE_LO, low bit of the BASE field and of the base range compare.
TOP_HI, `LM_TOP_HI, high bit of the TOP field; address bits above it must equal BASE.
TOP_LO, 4, low bit of the TOP field (16-byte granule).

Ports:
CLK  in  1  clock, all state on rising edge.
RST  in  1  asynchronous, active-high reset.
CFG_WE  in  1  config write strobe.
CFG_SEL  in  1  0 = BASE register, 1 = TOP register.
CFG_WDATA  in  32  config write data; for BASE, bit 0 = window enable.
CFG_BASE  out  32  readback: {BASE[31:BASE_LO], zeros, EN}.
CFG_TOP  out  32  readback: TOP[TOP_HI:TOP_LO] in place, other bits zero.
REQ_VALID  in  1  upstream request valid.
REQ_READY  out  1  upstream ready; registered.
REQ_ADDR  in  32  byte address.
REQ_WR  in  1  1 = store.
REQ_WDATA  in  32  store data.
REQ_BE  in  4  byte enables.
DRAM_VALID  out  1  head entry valid, routed to DRAM.
DRAM_READY  in  1  DRAM port accepts.
SYS_VALID  out  1  head entry valid, routed to system bus.
SYS_READY  in  1  system port accepts.
OUT_ADDR  out  32  head address, shared by both ports.
OUT_WR  out  1  head write flag.
OUT_WDATA  out  32  head store data.
OUT_BE  out  4  head byte enables.

Behaviour:
Reset (async on RST high):
- Queue emptied; count = 0.
- BASE = 0, EN = 0, TOP = 0.
- REQ_READY = 1; DRAM_VALID = 0; SYS_VALID = 0.
- OUT_* = 0; readbacks = 0.
- Reset mid-operation drops held entries silently.

Config write (CFG_WE high at an edge):
- Loads the selected register; the new value is visible from the next cycle.
- Route bits of entries already queued are never recomputed.
- If a config write and a request accept coincide, the route uses the pre-write register values.

Route computation (combinational on REQ_ADDR, sampled at accept):
- DRAM = EN & (REQ_ADDR[31:TOP_HI+1] == BASE[31:TOP_HI+1]) & (REQ_ADDR[TOP_HI:BASE_LO] >= BASE[TOP_HI:BASE_LO]) & (REQ_ADDR[TOP_HI:TOP_LO] <= TOP).
- Unsigned compares.
- The window test is the lmi_dram_cmp function, instantiated unmodified with this block's parameters.
- EN = 0 forces SYS.

Accept, queue and drain:
- Accept = REQ_VALID & REQ_READY; the accepted request plus its route bit are written at the tail.
- Queue: 2 entries, 1-bit read/write pointers that wrap, 2-bit count (0..2).
- REQ_READY next = (count_next < 2).
- Head drives OUT_* whenever count > 0. DRAM_VALID = (count > 0) & route; SYS_VALID = (count > 0) & ~route.
- Pop = (DRAM_VALID & DRAM_READY) | (SYS_VALID & SYS_READY).
- Latency: a request accepted at edge N is valid on its port in cycle N+1, minimum.
- Throughput: one request per cycle when downstream is always ready.

Boundary conditions:
- Push and pop in the same cycle: count unchanged.
- Push and pop in the same cycle with count = 2 is impossible, because REQ_READY = 0.
- Empty: valids low; OUT_* hold their last value.
- Ordering is strictly in order. A SYS head blocks a DRAM entry behind it; there is no bypass.
- Downstream valid, once asserted, stays high with OUT_* stable until the handshake completes.

Decomposition:
- Shared include lmi_symbols.vh: `LM_BASE_LO, `LM_TOP_HI, CFG_SEL encodings (LMI_CFG_BASE = 0, LMI_CFG_TOP = 1), enable bit position.
- One sub-module: lmi_dram_cmp, window compare on REQ_ADDR.
- Queue storage and pointers stay inline; no separate FIFO module.

Test Plan:
Bench instance uses BASE_LO = 12, TOP_HI = 23. Configuration for scenarios 1-3: BASE = 0x4000_0001, TOP = 0x00F_FFF0 (window 0x4000_0000..0x400F_FFFF).
1. Send 0x4000_0010 with DRAM_READY = 1 -> DRAM_VALID one cycle after accept, OUT_ADDR = 0x4000_0010, SYS_VALID = 0.
2. Send 0x4010_0000, 0x3FFF_FFF0 and 0x5000_0010 -> each appears on SYS, in order.
3. Hold DRAM_READY = 0 and offer three DRAM requests -> two accepted, REQ_READY = 0 after the second accept, head stable. Release DRAM_READY -> both drain on consecutive cycles and REQ_READY returns to 1.
4. Queue a DRAM-window request, then write BASE = 0x4000_0000 (EN = 0) -> the queued request still exits on DRAM; the next 0x4000_0010 exits on SYS.
5. Config write and accept in the same cycle -> the route follows the old register values.
6. Assert RST with two entries queued -> valids drop immediately, REQ_READY = 1, CFG_BASE = 0, and no stale entry emerges after reset is released.
